accumulate_unit: RTL



---
 rtl/accel_pkg.sv | 16 +
 rtl/accumulate_unit_adder.sv | 26 ++
 rtl/accumulate_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and default widths for the accumulate unit.
//   acc_state_t      : controller states of the reduction FSM
//   DEFAULT_BITWIDTH : default operand/accumulator width
//   DEFAULT_LEN_W    : default width of the vector-length field
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } acc_state_t;

  localparam int DEFAULT_BITWIDTH = 16;
  localparam int DEFAULT_LEN_W    = 8;

endpackage

// File: rtl/accumulate_unit_adder.sv
// Two's-complement adder/subtractor, modulo 2^BITWIDTH.
//   a, b     : operands
//   subtract : 1 = a - b, 0 = a + b
//   sum      : result; the carry-out is not produced
module accumulate_unit_adder
  import accel_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  logic                subtract,
  output logic [BITWIDTH-1:0] sum
);

  logic [BITWIDTH-1:0] b_eff_s;
  logic [BITWIDTH-1:0] cin_s;

  // Subtraction is a + ~b + 1; the +1 enters as the carry-in.
  always_comb begin
    b_eff_s = b ^ {BITWIDTH{subtract}};
    cin_s   = {{(BITWIDTH-1){1'b0}}, subtract};
    sum     = a + b_eff_s + cin_s;
  end

endmodule

// File: rtl/accumulate_unit.sv
// Sequential reduction stage: folds a handshaked operand stream into a
// running sum and emits one result per programmed vector length.
//   clk, rst            : clock, synchronous active-high reset
//   start, cfg_len      : begin a reduction of cfg_len beats (IDLE only)
//   in_valid/in_ready   : operand handshake; in_data, in_sub per beat
//   out_valid/out_ready : result handshake; out_data held until accepted
//   busy                : high whenever the FSM is not IDLE
//   beat_cnt            : beats accepted in the current reduction
module accumulate_unit
  import accel_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int LEN_W    = DEFAULT_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                busy,
  output logic [LEN_W-1:0]    beat_cnt
);

  acc_state_t          state_q, state_d;
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BITWIDTH-1:0] out_data_q, out_data_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [BITWIDTH-1:0] sum_s;
  logic [LEN_W-1:0]    beat_cnt_inc_s;

  accumulate_unit_adder #(
    .BITWIDTH(BITWIDTH)
  ) u_adder (
    .a        (acc_q),
    .b        (in_data),
    .subtract (in_sub),
    .sum      (sum_s)
  );

  // Next-state, datapath and output-flag logic.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    beat_cnt_d     = beat_cnt_q;
    len_d          = len_q;
    out_data_d     = out_data_q;
    beat_cnt_inc_s = beat_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = cfg_len;
          acc_d      = {BITWIDTH{1'b0}};
          beat_cnt_d = {LEN_W{1'b0}};
          if (cfg_len != {LEN_W{1'b0}}) begin
            state_d = ACCUM;
          end else begin
            // Empty vector: the result is zero and is presented at once.
            state_d    = OUTPUT;
            out_data_d = {BITWIDTH{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d      = sum_s;
          beat_cnt_d = beat_cnt_inc_s;
          // Last beat when the incremented count reaches the length;
          // reusing the increment avoids a separate len-1 subtractor.
          if (beat_cnt_inc_s == len_q) begin
            out_data_d = sum_s;
            state_d    = OUTPUT;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags are registered from the next state so they track state_q exactly.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {BITWIDTH{1'b0}};
      beat_cnt_q  <= {LEN_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      out_data_q  <= {BITWIDTH{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
